// File: rtl/pll_lock_ctrl_if.sv
// PFD sample stream into the PLL lock sequencer: signed phase error qualified by sample_valid.
interface pll_lock_ctrl_if #(
    parameter int DATA_W = 4
) ();
    logic signed [DATA_W-1:0] error_in;
    logic                     sample_valid;

    modport master (output error_in, output sample_valid);
    modport slave  (input  error_in, input  sample_valid);
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL acquisition/lock sequencer: windowed phase-error counting drives IDLE/CLEAR/ACQUIRE/TRACK/LOCKED.
// Define LOCK_STATS_EN to add the saturating lock_loss_cnt output.
module pll_lock_ctrl #(
    parameter int DATA_W      = 4,
    parameter int WIN_LEN     = 256,
    parameter int LOCK_THR    = 8,
    parameter int UNLOCK_THR  = 32,
    parameter int ACQ_WINS    = 2,
    parameter int LOCK_WINS   = 8,
    parameter int ACQ_TIMEOUT = 64,
    parameter int CLR_CYCLES  = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    pll_lock_ctrl_if.slave       pfd,
    output logic [1:0]           gain_sel,
    output logic                 lf_clr,
    output logic                 locked,
    output logic                 lock_lost,
    output logic                 acq_timeout,
    output logic [2:0]           state_out
`ifdef LOCK_STATS_EN
    ,
    output logic [7:0]           lock_loss_cnt
`endif
);
    localparam int WW   = $clog2(WIN_LEN);
    localparam int CW   = WW + 1;
    localparam int GMAX = (ACQ_WINS > LOCK_WINS) ? ACQ_WINS : LOCK_WINS;
    localparam int GW   = $clog2(GMAX + 1);
    localparam int TW   = $clog2(ACQ_TIMEOUT + 1);
    localparam int KW   = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    state_t            state;
    logic [WW-1:0]     win_cnt;
    logic [CW-1:0]     err_cnt;
    logic [GW-1:0]     good_cnt;
    logic [TW-1:0]     timeout_cnt;
    logic [KW-1:0]     clr_cnt;

    logic signed [DATA_W-1:0] err_s;
    logic              sample_err;
    logic              win_end;
    logic              win_good;
    logic              win_unlock;
    logic [CW-1:0]     err_final;
    logic [GW-1:0]     good_next;
    logic [TW-1:0]     tmo_next;

    function automatic logic [CW-1:0] err_sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TW-1:0] tmo_sat_inc(input logic [TW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef LOCK_STATS_EN
    function automatic logic [7:0] stat_sat_inc(input logic [7:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    // The window-end sample's own error is folded into the decision value.
    assign err_s      = pfd.error_in;
    assign sample_err = pfd.sample_valid && (err_s != '0);
    assign win_end    = pfd.sample_valid && (win_cnt == WW'(WIN_LEN - 1));
    assign err_final  = sample_err ? err_sat_inc(err_cnt) : err_cnt;
    assign win_good   = (err_final <= CW'(LOCK_THR));
    assign win_unlock = (err_final > CW'(UNLOCK_THR));
    assign good_next  = good_cnt + 1'b1;
    assign tmo_next   = tmo_sat_inc(timeout_cnt);
    assign state_out  = state;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gain_sel    <= 2'd2;
            lf_clr      <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            acq_timeout <= 1'b0;
            win_cnt     <= '0;
            err_cnt     <= '0;
            good_cnt    <= '0;
            timeout_cnt <= '0;
            clr_cnt     <= '0;
`ifdef LOCK_STATS_EN
            lock_loss_cnt <= '0;
`endif
        end else begin
            lock_lost   <= 1'b0;
            acq_timeout <= 1'b0;

            if (pfd.sample_valid) begin
                if (win_end) begin
                    win_cnt <= '0;
                    err_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    err_cnt <= err_final;
                end
            end

            // State entries below override the free-running window update above.
            if (!enable) begin
                state    <= ST_IDLE;
                gain_sel <= 2'd2;
                lf_clr   <= 1'b0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_CLEAR;
                        gain_sel <= 2'd2;
                        lf_clr   <= 1'b1;
                        clr_cnt  <= '0;
                        win_cnt  <= '0;
                        err_cnt  <= '0;
                        good_cnt <= '0;
                    end
                    ST_CLEAR: begin
                        if (clr_cnt == KW'(CLR_CYCLES - 1)) begin
                            state       <= ST_ACQUIRE;
                            lf_clr      <= 1'b0;
                            timeout_cnt <= '0;
                            win_cnt     <= '0;
                            err_cnt     <= '0;
                            good_cnt    <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (win_end) begin
                            timeout_cnt <= tmo_next;
                            if (win_good && (good_next == GW'(ACQ_WINS))) begin
                                state    <= ST_TRACK;
                                gain_sel <= 2'd1;
                                good_cnt <= '0;
                            end else if (tmo_next >= TW'(ACQ_TIMEOUT)) begin
                                state       <= ST_CLEAR;
                                lf_clr      <= 1'b1;
                                acq_timeout <= 1'b1;
                                clr_cnt     <= '0;
                                good_cnt    <= '0;
                            end else begin
                                good_cnt <= win_good ? good_next : '0;
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (win_end) begin
                            if (!win_good) begin
                                state    <= ST_ACQUIRE;
                                gain_sel <= 2'd2;
                                good_cnt <= '0;
                            end else if (good_next == GW'(LOCK_WINS)) begin
                                state    <= ST_LOCKED;
                                gain_sel <= 2'd0;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_next;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (win_end && win_unlock) begin
                            state       <= ST_ACQUIRE;
                            gain_sel    <= 2'd2;
                            locked      <= 1'b0;
                            lock_lost   <= 1'b1;
                            timeout_cnt <= '0;
                            good_cnt    <= '0;
`ifdef LOCK_STATS_EN
                            lock_loss_cnt <= stat_sat_inc(lock_loss_cnt);
`endif
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        gain_sel <= 2'd2;
                        lf_clr   <= 1'b0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: vector table plus window-shaped sequences, checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;
    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              sv;
    logic signed [3:0] err;
    logic [1:0]        gain_sel;
    logic              lf_clr, locked, lock_lost, acq_timeout;
    logic [2:0]        state_out;
`ifdef LOCK_STATS_EN
    logic [7:0]        lock_loss_cnt;
`endif

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 sys_clk = ~sys_clk;

    pll_lock_ctrl_if #(.DATA_W(4)) pfd_if ();
    assign pfd_if.error_in     = err;
    assign pfd_if.sample_valid = sv;

    pll_lock_ctrl dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pfd         (pfd_if),
        .gain_sel    (gain_sel),
        .lf_clr      (lf_clr),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .acq_timeout (acq_timeout),
        .state_out   (state_out)
`ifdef LOCK_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    typedef struct {
        string             name;
        logic              en;
        logic              sv;
        logic signed [3:0] err;
        int                cycles;
        logic [8:0]        outs;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] outs;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_a;

    function automatic logic [8:0] pk(input logic [2:0] st, input logic [1:0] g,
                                      input logic lf, input logic lk,
                                      input logic ll, input logic at);
        return {st, g, lf, lk, ll, at};
    endfunction

    function automatic vec_t mkv(input string name, input logic en, input logic s,
                                 input logic signed [3:0] e, input int cyc,
                                 input logic [8:0] outs);
        vec_t v;
        v.name = name; v.en = en; v.sv = s; v.err = e; v.cycles = cyc; v.outs = outs;
        return v;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check_out();
        exp_t       e;
        logic [8:0] act;
        vectors_applied++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got no expected entry, want one queued");
            return;
        end
        e   = sb.pop_front();
        act = {state_out, gain_sel, lf_clr, locked, lock_lost, acq_timeout};
        if (act !== e.outs) begin
            miscompares++;
            $display("FAIL %s: got st=%0d gain=%0d lf_clr=%b locked=%b lock_lost=%b acq_timeout=%b; want st=%0d gain=%0d lf_clr=%b locked=%b lock_lost=%b acq_timeout=%b",
                     e.name, act[8:6], act[5:4], act[3], act[2], act[1], act[0],
                     e.outs[8:6], e.outs[5:4], e.outs[3], e.outs[2], e.outs[1], e.outs[0]);
        end
    endtask

    task automatic push_exp(input string name, input logic [8:0] outs);
        exp_t x;
        x.name = name;
        x.outs = outs;
        sb.push_back(x);
    endtask

    task automatic want(input string name, input logic [8:0] outs);
        push_exp(name, outs);
        check_out();
    endtask

    task automatic apply(input vec_t v);
        enable = v.en;
        sv     = v.sv;
        err    = v.err;
        push_exp(v.name, v.outs);
        step(v.cycles);
        check_out();
    endtask

`ifdef LOCK_STATS_EN
    task automatic check_stat(input string name, input logic [7:0] exp_cnt);
        vectors_applied++;
        if (lock_loss_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s: got lock_loss_cnt=%0d, want %0d", name, lock_loss_cnt, exp_cnt);
        end
    endtask
`endif

    // n qualified samples; the first nerr carry error e. Optional invalid cycles carry nonzero error.
    task automatic run_samples(input int n, input int nerr, input logic signed [3:0] e,
                               input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 8 == 3)) begin
                sv  = 1'b0;
                err = 4'sd1;
                step(1);
            end
            sv  = 1'b1;
            err = (i < nerr) ? e : 4'sd0;
            step(1);
        end
        sv  = 1'b0;
        err = 4'sd0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        sv     = 1'b0;
        err    = 4'sd0;

        // Part A: clean acquisition from enable rise (cycle 0).
        tbl.push_back(mkv("idle",      1'b0, 1'b1, 4'sd0,    1, pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("clr_c1",    1'b1, 1'b1, 4'sd0,    1, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("clr_c4",    1'b1, 1'b1, 4'sd0,    3, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("acq_c5",    1'b1, 1'b1, 4'sd0,    1, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("acq_c516",  1'b1, 1'b1, 4'sd0,  511, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("trk_c517",  1'b1, 1'b1, 4'sd0,    1, pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("trk_c2564", 1'b1, 1'b1, 4'sd0, 2047, pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("lck_c2565", 1'b1, 1'b1, 4'sd0,    1, pk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        n_a = tbl.size();
        // Part B: enable drop in CLEAR, then continuous error forcing acquire timeouts.
        tbl.push_back(mkv("idle_b",     1'b0, 1'b1, 4'sd0,      2, pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("clr_c2",     1'b1, 1'b1, 4'sd0,      2, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("drop_clr",   1'b0, 1'b1, 4'sd0,      1, pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("stay_idle",  1'b0, 1'b1, 4'sd0,      5, pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_acq",    1'b1, 1'b1, 4'sd1,      5, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_pre",    1'b1, 1'b1, 4'sd1,  16383, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_pulse",  1'b1, 1'b1, 4'sd1,      1, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1)));
        tbl.push_back(mkv("tmo_clr2",   1'b1, 1'b1, 4'sd1,      1, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_clr4",   1'b1, 1'b1, 4'sd1,      2, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_reacq",  1'b1, 1'b1, 4'sd1,      1, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_pre2",   1'b1, 1'b1, 4'sd1,  16383, pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mkv("tmo_pulse2", 1'b1, 1'b1, 4'sd1,      1, pk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1)));

        step(2);
        want("reset", pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef LOCK_STATS_EN
        check_stat("stat_reset", 8'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < n_a; i++) apply(tbl[i]);

        // Loss of lock: 32 errors tolerated, 33 drops to ACQUIRE.
        run_samples(256, 32, 4'sd1, 1'b1);
        want("lck_32err", pk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_samples(256, 33, -4'sd1, 1'b1);
        want("unlock_33err", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef LOCK_STATS_EN
        check_stat("stat_one_loss", 8'd1);
`endif
        step(1);
        want("unlock_pulse_end", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));

        // Good-window threshold in ACQUIRE: 8 good, 9 bad and resets the good count.
        run_samples(256, 8, 4'sd1, 1'b0);
        want("acq_8err_good", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(256, 9, 4'sd1, 1'b0);
        want("acq_9err_bad", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(256, 8, -4'sd1, 1'b1);
        want("acq_good_after_bad", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(256, 8, 4'sd1, 1'b0);
        want("trk_enter", pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(1792, 0, 4'sd0, 1'b0);
        want("trk_7good", pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(256, 8, 4'sd1, 1'b1);
        want("relock", pk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Asynchronous reset between clock edges while LOCKED.
        #2;
        rst_n = 1'b0;
        #1;
        want("async_rst", pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef LOCK_STATS_EN
        check_stat("stat_async_rst", 8'd0);
`endif
        step(2);
        want("rst_held", pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;

        // Enable drop on the window end that would otherwise enter LOCKED.
        enable = 1'b1;
        sv     = 1'b1;
        err    = 4'sd0;
        step(5);
        want("re_acq", pk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(512, 0, 4'sd0, 1'b0);
        want("re_trk", pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(1792, 0, 4'sd0, 1'b0);
        want("re_trk_7good", pk(3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        run_samples(255, 0, 4'sd0, 1'b0);
        enable = 1'b0;
        sv     = 1'b1;
        err    = 4'sd0;
        step(1);
        want("drop_at_wend", pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        step(3);
        want("drop_stay_idle", pk(3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = n_a; i < tbl.size(); i++) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Acquisition and lock sequencer for the digital PLL loop. It monitors the PFD phase-error stream (error_out/sample_en) in fixed-length windows and steps the loop through clear, acquire, track and locked phases. It drives loop-filter gain selection and the filter clear, and reports lock status. It sits between the PFD and the loop filter, in the sys_clk domain.

Parameters:
WIN_LEN, 256, sample_en-qualified cycles per evaluation window (power of 2, ≥16)
LOCK_THR, 8, max error cycles per window for a "good" window
UNLOCK_THR, 32, error cycles per window above which LOCKED is lost (≥LOCK_THR)
ACQ_WINS, 2, consecutive good windows in ACQUIRE to enter TRACK
LOCK_WINS, 8, consecutive good windows in TRACK to enter LOCKED
ACQ_TIMEOUT, 64, windows allowed in ACQUIRE before forced re-clear
CLR_CYCLES, 4, lf_clr pulse length in cycles

Ports:
sys_clk  in  1  system clock (100 MHz); single clock domain
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; low forces IDLE
error_in  in  4 (signed)  PFD phase error (+1/0/-1)
sample_valid  in  1  PFD sample enable; qualifies error_in
gain_sel  out  2  loop-filter gain: 2=high (acquire), 1=mid (track), 0=low (locked)
lf_clr  out  1  loop-filter integrator clear
locked  out  1  lock indicator
lock_lost  out  1  1-cycle pulse on LOCKED→ACQUIRE
acq_timeout  out  1  1-cycle pulse on ACQUIRE timeout
state_out  out  3  current state encoding (debug)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gain_sel=2; lf_clr=0; locked=0; lock_lost=0; acq_timeout=0; all counters 0.
- States/encoding: IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3, LOCKED=4; other codes → IDLE.
- Window: win_cnt advances only on cycles with sample_valid=1. err_cnt increments when sample_valid=1 and error_in≠0, saturating at all-ones (width clog2(WIN_LEN)+1). Window end = sample_valid=1 and win_cnt=WIN_LEN-1; the end cycle's error is included. At window end, win_cnt and err_cnt clear; the decision is registered and takes effect the next cycle.
- Good window: err_cnt_final ≤ LOCK_THR. Bad LOCKED window: err_cnt_final > UNLOCK_THR.
- Entering any of CLEAR/ACQUIRE/TRACK/LOCKED clears win_cnt, err_cnt and good_cnt. timeout_cnt clears on entering ACQUIRE from CLEAR only.
- IDLE: gain_sel=2, outputs low. enable=1 → CLEAR.
- CLEAR: lf_clr=1 for exactly CLR_CYCLES cycles, gain_sel=2, then → ACQUIRE.
- ACQUIRE: gain_sel=2. Each window end: timeout_cnt++. Good → good_cnt++; good_cnt reaching ACQ_WINS → TRACK. Bad → good_cnt=0. timeout_cnt reaching ACQ_TIMEOUT without a TRACK transition → CLEAR with acq_timeout pulse. If both conditions occur on the same window, TRACK wins.
- TRACK: gain_sel=1. Good → good_cnt++; reaching LOCK_WINS → LOCKED. Any non-good window → ACQUIRE (timeout_cnt keeps counting).
- LOCKED: gain_sel=0, locked=1. Windows with LOCK_THR < err ≤ UNLOCK_THR are tolerated. err > UNLOCK_THR → ACQUIRE: lock_lost pulse and locked=0 on the same cycle the state changes; timeout_cnt cleared.
- enable=0 in any state → IDLE next cycle; this has priority over window decisions. lf_clr deasserts immediately.
- error_in is ignored when sample_valid=0. No combinational paths from input to output.

Optional Feature:
LOCK_STATS_EN: when defined, add output lock_loss_cnt[7:0]. It increments on each lock_lost pulse, saturates at 255 and clears only on rst_n. When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 mid-LOCKED → immediate state_out=0, locked=0, gain_sel=2, lf_clr=0, independent of clock.
- Clean acquire (defaults, sample_valid=1, error_in=0): enable rises at cycle 0 → lf_clr high cycles 1–4; ACQUIRE at 5; TRACK (gain_sel=1) at 517; LOCKED (locked=1, gain_sel=0) at 2565.
- Threshold edge: in ACQUIRE, 8 error cycles per window → counts good; 9 → bad, good_cnt reset, no TRACK.
- Loss of lock: in LOCKED, a window with 32 errors → stays LOCKED; a window with 33 errors → one lock_lost pulse, locked=0, gain_sel=2, state=ACQUIRE. With LOCK_STATS_EN, lock_loss_cnt=1.
- Timeout: error_in=+1 continuously → acq_timeout pulses after 64 windows, lf_clr=1 for 4 cycles, then ACQUIRE again. Repeats every 64 windows plus 4 cycles.
- Enable drop: deassert enable during CLEAR cycle 2 and on a TRACK window-end cycle → IDLE next cycle, lf_clr=0, no TRACK/LOCKED transition.
